// File: rtl/full_subtractor_pkg.sv
// Shared constants and types for the registered full subtractor.
package full_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 1;

  localparam logic D_RST_BIT     = 1'b0;
  localparam logic BOUT_RST      = 1'b0;
  localparam logic OVF_RST       = 1'b0;
  localparam logic OUT_VALID_RST = 1'b0;

  // {bout, d} at the default width; the top derives its own WIDTH+1 form.
  typedef logic [WIDTH_DEFAULT:0] fsub_res_t;

  // Signed overflow of a - b: operands differ in sign and the result sign differs from a.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor cell: d_i = a_i - b_i - b_in, with borrow-out.
module full_subtractor_cell
  import full_subtractor_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic b_in,
  output logic d_i,
  output logic b_out
);

  assign d_i   = a_i ^ b_i ^ b_in;
  assign b_out = (~a_i & b_i) | (~a_i & b_in) | (b_i & b_in);

endmodule

// File: rtl/full_subtractor_bf.sv
// Registered ripple-borrow subtractor {bout, d} = a - b - bin with a valid flag.
// Optional signed-overflow output is enabled by defining FULLSUB_OVF_EN.
module full_subtractor_bf
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d,
  output logic             bout,
`ifdef FULLSUB_OVF_EN
  output logic             out_valid,
  output logic             ovf
`else
  output logic             out_valid
`endif
);

  typedef logic [WIDTH:0] res_t;

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff_next;
  res_t             res_next;

  assign borrow[0] = bin;

  // Ripple chain, LSB to MSB: each cell's borrow-out feeds the next cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .b_in (borrow[i]),
      .d_i  (diff_next[i]),
      .b_out(borrow[i+1])
    );
  end

  assign res_next = {borrow[WIDTH], diff_next};

  logic [WIDTH-1:0] d_d, d_q;
  logic             bout_d, bout_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    d_d         = d_q;
    bout_d      = bout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      d_d    = res_next[WIDTH-1:0];
      bout_d = res_next[WIDTH];
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= {WIDTH{D_RST_BIT}};
      bout_q      <= BOUT_RST;
      out_valid_q <= OUT_VALID_RST;
    end else begin
      d_q         <= d_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign d         = d_q;
  assign bout      = bout_q;
  assign out_valid = out_valid_q;

`ifdef FULLSUB_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = signed_ovf(a[WIDTH-1], b[WIDTH-1], diff_next[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= OVF_RST;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_subtractor_bf.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against an integer reference model.
module tb_full_subtractor_bf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a1, b1, bin1, iv1;
  logic       d1, bout1, ov1;
  logic [7:0] a8, b8, d8;
  logic       bin8, iv8, bout8, ov8;
`ifdef FULLSUB_OVF_EN
  logic       ovf1, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t h1, h8;
  logic v1, v8;

  always #5 clk = ~clk;

  full_subtractor_bf #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a1),
    .b        (b1),
    .bin      (bin1),
    .in_valid (iv1),
    .d        (d1),
    .bout     (bout1),
`ifdef FULLSUB_OVF_EN
    .out_valid(ov1),
    .ovf      (ovf1)
`else
    .out_valid(ov1)
`endif
  );

  full_subtractor_bf #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a8),
    .b        (b8),
    .bin      (bin8),
    .in_valid (iv8),
    .d        (d8),
    .bout     (bout8),
`ifdef FULLSUB_OVF_EN
    .out_valid(ov8),
    .ovf      (ovf8)
`else
    .out_valid(ov8)
`endif
  );

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int mask, half, ua, ub, r, sa, sb, rs;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    r  = ua - ub - int'(bin);
    e.d    = 8'(r & mask);
    e.bout = (r < 0);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    rs = sa - sb - int'(bin);
    e.ovf  = (rs < -half) || (rs > half - 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic a, input logic b, input logic bin);
    a1 = a; b1 = b; bin1 = bin; iv1 = 1'b1;
    q1.push_back(model(1, {7'b0, a}, {7'b0, b}, bin));
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    a8 = a; b8 = b; bin8 = bin; iv8 = 1'b1;
    q8.push_back(model(8, a, b, bin));
  endtask

  task automatic check_outputs();
    chk("w1_out_valid", {7'b0, ov1}, {7'b0, v1});
    if (v1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $error("FAIL w1_scoreboard observed=empty expected=entry");
      end else h1 = q1.pop_front();
    end
    chk("w1_d", {7'b0, d1}, h1.d);
    chk("w1_bout", {7'b0, bout1}, {7'b0, h1.bout});
`ifdef FULLSUB_OVF_EN
    chk("w1_ovf", {7'b0, ovf1}, {7'b0, h1.ovf});
`endif
    chk("w8_out_valid", {7'b0, ov8}, {7'b0, v8});
    if (v8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $error("FAIL w8_scoreboard observed=empty expected=entry");
      end else h8 = q8.pop_front();
    end
    chk("w8_d", d8, h8.d);
    chk("w8_bout", {7'b0, bout8}, {7'b0, h8.bout});
`ifdef FULLSUB_OVF_EN
    chk("w8_ovf", {7'b0, ovf8}, {7'b0, h8.ovf});
`endif
  endtask

  task automatic tick();
    v1 = iv1;
    v8 = iv8;
    @(posedge clk);
    #1;
    check_outputs();
    iv1 = 1'b0;
    iv8 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_w1_d"}, {7'b0, d1}, 8'h00);
    chk({tag, "_w1_bout"}, {7'b0, bout1}, 8'h00);
    chk({tag, "_w1_vld"}, {7'b0, ov1}, 8'h00);
    chk({tag, "_w8_d"}, d8, 8'h00);
    chk({tag, "_w8_bout"}, {7'b0, bout8}, 8'h00);
    chk({tag, "_w8_vld"}, {7'b0, ov8}, 8'h00);
`ifdef FULLSUB_OVF_EN
    chk({tag, "_w1_ovf"}, {7'b0, ovf1}, 8'h00);
    chk({tag, "_w8_ovf"}, {7'b0, ovf8}, 8'h00);
`endif
  endtask

  initial begin
    a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0; iv1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0; iv8 = 1'b0;
    h1 = '0; h8 = '0;
    v1 = 1'b0; v8 = 1'b0;

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      drive1(i[2], i[1], i[0]);
      tick();
    end

    // WIDTH=8 directed vectors, including borrow wrap and signed overflow
    drive8(8'h00, 8'h00, 1'b1); tick();
    drive8(8'hA5, 8'h25, 1'b0); tick();
    drive8(8'h80, 8'h01, 1'b0); tick();
    drive8(8'h05, 8'h03, 1'b0); tick();
    drive8(8'h7F, 8'hFF, 1'b1); tick();
    drive8(8'hFF, 8'hFF, 1'b1); tick();

    // Random back-to-back traffic on both widths
    for (int i = 0; i < 12; i++) begin
      drive8(8'($urandom), 8'($urandom), 1'($urandom));
      drive1(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end

    // Hold: one valid vector then three idle cycles
    drive8(8'h3C, 8'h5A, 1'b1);
    drive1(1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) tick();

    // Asynchronous reset between edges with nonzero outputs
    drive8(8'h00, 8'h01, 1'b0);
    drive1(1'b1, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    q1.delete(); q8.delete();
    h1 = '0; h8 = '0;
    #2;
    rst_n = 1'b1;
    drive1(1'b1, 1'b0, 1'b0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_subtractor_bf.md
# full_subtractor_bf

Registered full subtractor producing difference and borrow-out from two operands and a borrow-in. Bit-serial-composable: one borrow-in, one borrow-out, so instances chain into wider subtractors. Datapath is a ripple-borrow chain of one-bit cells, followed by a single output register stage with a valid flag. It is a leaf arithmetic block in the adders/subtractors library.

## Interface
- Clocking: one clock `clk`, rising-edge. Reset `rst_n` is asynchronous and active-low.
- Parameter `WIDTH`, default 1: operand and difference width in bits, must be ≥ 1.
- `clk` — input, 1 bit: rising-edge clock.
- `rst_n` — input, 1 bit: asynchronous active-low reset.
- `a` — input, `WIDTH` bits: minuend, unsigned.
- `b` — input, `WIDTH` bits: subtrahend, unsigned.
- `bin` — input, 1 bit: borrow-in, weight 1 at LSB.
- `in_valid` — input, 1 bit: operands valid this cycle.
- `d` — output, `WIDTH` bits: registered difference.
- `bout` — output, 1 bit: registered borrow-out from the MSB.
- `out_valid` — output, 1 bit: `d`/`bout` updated from a valid input.
- `ovf` — output, 1 bit, present only with `FULLSUB_OVF_EN`: registered signed overflow.

## Operation
- Arithmetic: {bout, d} = a − b − bin, computed at WIDTH+1 bits in two's complement.
  - `d` = (a − b − bin) mod 2^WIDTH.
  - `bout` = 1 exactly when a < b + bin, unsigned.
- Per-bit cell, with `bi` as the borrow into bit i and `bi+1` as the borrow out of bit i:
  - d_i = a_i ^ b_i ^ bi
  - bi+1 = (~a_i & b_i) | (~a_i & bi) | (b_i & bi)
  - b0 = bin; `bout` = bWIDTH.
- `in_valid` = 1 at a rising edge: register the combinational result and set `out_valid` = 1.
- `in_valid` = 0 at a rising edge: `d`, `bout` (and `ovf`) hold their values; `out_valid` = 0.
- No back-pressure. The block accepts every cycle.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Throughput is one operation per cycle.
- Reset values: `d` = 0, `bout` = 0, `ovf` = 0, `out_valid` = 0.
  - Applied immediately on `rst_n` falling, independent of `clk`.
- Reset asserted mid-operation discards the in-flight result. The first edge after deassertion with `in_valid` = 1 produces a fresh result.
- Outputs are glitch-free: driven only from flops.
- Combinational path from inputs to flop D is WIDTH cells deep (ripple). No lookahead.

## Configuration
- Macro `FULLSUB_OVF_EN`.
- Defined: port `ovf` exists. ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ d_next[MSB]), treating a, b as signed. It is registered alongside `d` with the same hold and reset rules.
- Undefined: no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- Package `full_subtractor_pkg` holds:
  - `WIDTH_DEFAULT` = 1;
  - reset constants for `d`, `bout`, `ovf`, `out_valid` (all zero);
  - a typedef for the WIDTH+1 result vector.
- Sub-module `full_subtractor_cell`: purely combinational one-bit cell (a_i, b_i, bi → d_i, bi+1) using the equations above.
- The top instantiates WIDTH cells in a generate loop, chained LSB to MSB, followed by the output register stage.

## Test plan
- WIDTH=1, sweep {a,b,bin} = 000…111 with `in_valid` = 1, one vector per cycle. Expected {d,bout} one cycle later:
  - 000 → 0,0
  - 001 → 1,1
  - 010 → 1,1
  - 011 → 0,1
  - 100 → 1,0
  - 101 → 0,0
  - 110 → 0,0
  - 111 → 1,1
- WIDTH=8, a=0x00, b=0x00, bin=1 → d=0xFF, bout=1. Then a=0xA5, b=0x25, bin=0 → d=0x80, bout=0.
- Hold: apply a valid vector, then drop `in_valid` for 3 cycles → `d`/`bout` unchanged and `out_valid` = 0 for those cycles.
- Async reset: pull `rst_n` low between clock edges while outputs are nonzero → all outputs are 0 before the next edge. Release `rst_n`, apply 1,0,0 at WIDTH=1 → d=1, bout=0 after the next edge.
- With `FULLSUB_OVF_EN`, WIDTH=8, a=0x80, b=0x01, bin=0 → d=0x7F, bout=0, ovf=1. Then a=0x05, b=0x03 → ovf=0.
